// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited sequential fetch from a 2-cycle BRAM
// into a small FIFO, with redirect flush and a valid/ready handshake toward decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          MEM_LATENCY = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    output logic [11:0] imem_addr_out,
    input  logic [31:0] imem_data_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    input  logic        ready_in,
    output logic        valid_out,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } tag_t;

    logic [31:0] fpc_q, fpc_d;
    tag_t        tag_q [MEM_LATENCY];
    tag_t        tag_d [MEM_LATENCY];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0] fifo_inst_q [FIFO_DEPTH];
    logic [31:0] fifo_pc_q   [FIFO_DEPTH];

    logic [CNT_W:0] level;
    logic           issue;
    logic           push;
    logic           pop;

    // Branch targets are word aligned; the byte-offset bits are deliberately dropped.
    logic unused_redirect_bits;
    assign unused_redirect_bits = ^redirect_pc_in[1:0];

    assign imem_addr_out = fpc_q[13:2];
    assign valid_out     = (count_q != '0);
    assign inst_out      = valid_out ? fifo_inst_q[rd_ptr_q] : '0;
    assign pc_out        = valid_out ? fifo_pc_q[rd_ptr_q]   : '0;

    always_comb begin
        // NOTE: blocking '=' is correct inside always_comb; the running sum below relies on it.
        level = {1'b0, count_q};
        for (int i = 0; i < MEM_LATENCY; i++) begin
            level = level + {{CNT_W{1'b0}}, tag_q[i].valid};
        end
        issue = (level < DEPTH_L);
        push  = tag_q[MEM_LATENCY-1].valid && !redirect_in;
        pop   = valid_out && ready_in;

        fpc_d    = fpc_q;
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (issue) begin
            fpc_d = fpc_q + 32'd4;
        end
        tag_d[0] = '{valid: issue, pc: fpc_q};
        for (int i = 1; i < MEM_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A redirect overrides everything: drop buffered and in-flight work, restart at target.
        if (redirect_in) begin
            fpc_d    = {redirect_pc_in[31:2], 2'b00};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                tag_d[i].valid = 1'b0;
            end
        end
    end

    // NOTE: state flops use non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            fpc_q    <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            fpc_q    <= fpc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            tag_q    <= tag_d;
        end
    end

    // NOTE: the FIFO storage is not reset; the outputs are masked while the FIFO is empty,
    // so stale entries are never visible and the array can map to plain registers or LUTRAM.
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_inst_q[wr_ptr_q] <= imem_data_in;
            fifo_pc_q[wr_ptr_q]   <= tag_q[MEM_LATENCY-1].pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: BRAM model with 2-cycle latency, scoreboard of
// expected PCs checked on every handshake, plus cycle-exact directed checks.
module tb_fetch_unit;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [11:0] imem_addr_out;
    logic [31:0] imem_data_in;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic        ready_in;
    logic        valid_out;
    logic [31:0] inst_out;
    logic [31:0] pc_out;

    int errors = 0;
    int checks = 0;
    logic [31:0] sb [$];

    logic [31:0] mem_d1, mem_d2;

    fetch_unit dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .imem_addr_out (imem_addr_out),
        .imem_data_in  (imem_data_in),
        .redirect_in   (redirect_in),
        .redirect_pc_in(redirect_pc_in),
        .ready_in      (ready_in),
        .valid_out     (valid_out),
        .inst_out      (inst_out),
        .pc_out        (pc_out)
    );

    always #5 clk_in = ~clk_in;

    // Instruction memory: word i holds 0x1000_0000 + i, read data two cycles after the address.
    always @(posedge clk_in) begin
        mem_d1 <= 32'h1000_0000 + {20'h0, imem_addr_out};
        mem_d2 <= mem_d1;
    end
    assign imem_data_in = mem_d2;

    function automatic logic [31:0] exp_inst(input logic [31:0] pc);
        return 32'h1000_0000 + {20'h0, pc[13:2]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back(base + 32'(4 * i));
        end
    endtask

    // Sample at the falling edge, score any handshake, then move to 1 ns after the next rising edge.
    task automatic tick();
        logic [31:0] e;
        @(negedge clk_in);
        if (rst_in && valid_out && ready_in) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_extra: got pc %h expected no delivery", pc_out);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_pc", pc_out, e);
                check("sb_inst", inst_out, exp_inst(e));
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    task automatic reset_dut();
        rst_in      = 1'b0;
        redirect_in = 1'b0;
        ready_in    = 1'b0;
        run(2);
        check("sb_drain", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        rst_in         = 1'b0;
        redirect_in    = 1'b0;
        redirect_pc_in = '0;
        ready_in       = 1'b0;
        @(posedge clk_in);
        #1;
        run(2);

        // Reset state
        check("rst_valid", {31'h0, valid_out}, 32'd0);
        check("rst_inst", inst_out, 32'd0);
        check("rst_pc", pc_out, 32'd0);
        check("rst_addr", {20'h0, imem_addr_out}, 32'd0);

        // Streaming from reset: one instruction per cycle from cycle 3
        push_seq(32'h0, 8);
        rst_in   = 1'b1;
        ready_in = 1'b1;
        check("s1_addr_c0", {20'h0, imem_addr_out}, 32'h0);
        tick();
        check("s1_addr_c1", {20'h0, imem_addr_out}, 32'h1);
        tick();
        check("s1_valid_c2", {31'h0, valid_out}, 32'd0);
        tick();
        for (int c = 3; c <= 10; c++) begin
            check("s1_valid_stream", {31'h0, valid_out}, 32'd1);
            tick();
        end
        reset_dut();

        // Backpressure from cycle 0: four buffered, fetch stalls at 0x10
        rst_in   = 1'b1;
        ready_in = 1'b0;
        run(5);
        check("s2_addr_stall_c5", {20'h0, imem_addr_out}, 32'h4);
        run(2);
        check("s2_addr_stall_c7", {20'h0, imem_addr_out}, 32'h4);
        check("s2_hold_valid", {31'h0, valid_out}, 32'd1);
        check("s2_hold_pc", pc_out, 32'h0);
        check("s2_hold_inst", inst_out, 32'h1000_0000);
        tick();
        push_seq(32'h0, 8);
        ready_in = 1'b1;
        for (int c = 8; c <= 15; c++) begin
            check("s2_valid_drain", {31'h0, valid_out}, 32'd1);
            tick();
        end
        reset_dut();

        // Single redirect to 0x103 in cycle 10
        push_seq(32'h0, 8);
        rst_in   = 1'b1;
        ready_in = 1'b1;
        run(10);
        redirect_in    = 1'b1;
        redirect_pc_in = 32'h0000_0103;
        tick();
        redirect_in = 1'b0;
        push_seq(32'h100, 4);
        check("s3_addr_c11", {20'h0, imem_addr_out}, 32'h40);
        for (int c = 11; c <= 13; c++) begin
            check("s3_valid_low", {31'h0, valid_out}, 32'd0);
            tick();
        end
        check("s3_valid_c14", {31'h0, valid_out}, 32'd1);
        check("s3_pc_c14", pc_out, 32'h100);
        run(4);
        reset_dut();

        // Back-to-back redirects: 0x200 then 0x300, last one wins
        push_seq(32'h0, 8);
        rst_in   = 1'b1;
        ready_in = 1'b1;
        run(10);
        redirect_in    = 1'b1;
        redirect_pc_in = 32'h0000_0200;
        tick();
        redirect_pc_in = 32'h0000_0300;
        check("s4_valid_c11", {31'h0, valid_out}, 32'd0);
        tick();
        redirect_in = 1'b0;
        push_seq(32'h300, 3);
        check("s4_addr_c12", {20'h0, imem_addr_out}, 32'hC0);
        for (int c = 12; c <= 14; c++) begin
            check("s4_valid_low", {31'h0, valid_out}, 32'd0);
            tick();
        end
        check("s4_pc_c15", pc_out, 32'h300);
        run(3);
        reset_dut();

        // Redirect near the top of the address space: PC and word address wrap
        push_seq(32'h0, 8);
        rst_in   = 1'b1;
        ready_in = 1'b1;
        run(10);
        redirect_in    = 1'b1;
        redirect_pc_in = 32'hFFFF_FFF8;
        tick();
        redirect_in = 1'b0;
        push_seq(32'hFFFF_FFF8, 3);
        check("s5_addr_c11", {20'h0, imem_addr_out}, 32'hFFE);
        tick();
        check("s5_addr_c12", {20'h0, imem_addr_out}, 32'hFFF);
        tick();
        check("s5_addr_c13", {20'h0, imem_addr_out}, 32'h000);
        run(4);
        reset_dut();

        // One-cycle reset pulse while the FIFO is full
        rst_in   = 1'b1;
        ready_in = 1'b0;
        run(8);
        check("s6_full_valid", {31'h0, valid_out}, 32'd1);
        rst_in = 1'b0;
        #1;
        check("s6_async_valid", {31'h0, valid_out}, 32'd0);
        check("s6_async_pc", pc_out, 32'd0);
        check("s6_async_inst", inst_out, 32'd0);
        tick();
        rst_in   = 1'b1;
        ready_in = 1'b1;
        push_seq(32'h0, 3);
        check("s6_addr_c0", {20'h0, imem_addr_out}, 32'h0);
        run(2);
        check("s6_valid_c2", {31'h0, valid_out}, 32'd0);
        tick();
        check("s6_valid_c3", {31'h0, valid_out}, 32'd1);
        run(3);
        reset_dut();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
